// File: rtl/sdram_client_port_if.sv
// rtl/sdram_client_port_if.sv - CPU-side and controller-side signal bundle for sdram_client_port
// Ports (slave = the client port, master = the CPU/controller side):
//   cpu_valid/cpu_we/cpu_addr/cpu_din/cpu_wrl/cpu_wrh  request into the port
//   cpu_ready/cpu_rvalid/cpu_rdata                     accept and read-return
//   mem_addr/mem_din/mem_wrl/mem_wrh/mem_req           toggle-request to the controller
//   mem_ack/mem_dout                                   toggle-acknowledge and read data
interface sdram_client_port_if;
  logic        cpu_valid;
  logic        cpu_we;
  logic [24:1] cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_wrl;
  logic        cpu_wrh;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;
  logic [24:1] mem_addr;
  logic [15:0] mem_din;
  logic        mem_wrl;
  logic        mem_wrh;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_dout;

  modport slave (
    input  cpu_valid, cpu_we, cpu_addr, cpu_din, cpu_wrl, cpu_wrh,
    output cpu_ready, cpu_rvalid, cpu_rdata,
    output mem_addr, mem_din, mem_wrl, mem_wrh, mem_req,
    input  mem_ack, mem_dout
  );

  modport master (
    output cpu_valid, cpu_we, cpu_addr, cpu_din, cpu_wrl, cpu_wrh,
    input  cpu_ready, cpu_rvalid, cpu_rdata,
    input  mem_addr, mem_din, mem_wrl, mem_wrh, mem_req,
    output mem_ack, mem_dout
  );
endinterface

// File: rtl/sdram_client_port.sv
// rtl/sdram_client_port.sv - CPU client port with posted-write FIFO onto a toggle-handshake SDRAM controller port
// Ports:
//   clk    rising-edge clock shared with the SDRAM controller
//   reset  synchronous, active-high
//   bus    sdram_client_port_if.slave (CPU request/response and controller toggle port)
// DEPTH (2, 4 or 8) sets the number of posted-write entries.
module sdram_client_port #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  sdram_client_port_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, WR_BUSY, RD_ISSUE, RD_BUSY} state_t;

  typedef struct packed {
    logic [24:1] addr;
    logic [15:0] din;
    logic        wrl;
    logic        wrh;
  } wr_entry_t;

  state_t        state_q, state_d;
  wr_entry_t     fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_pending_q, rd_pending_d;
  logic [24:1]   rd_addr_q, rd_addr_d;
  logic [24:1]   mem_addr_q, mem_addr_d;
  logic [15:0]   mem_din_q, mem_din_d;
  logic          mem_wrl_q, mem_wrl_d;
  logic          mem_wrh_q, mem_wrh_d;
  logic          mem_req_q, mem_req_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [15:0]   cpu_rdata_q, cpu_rdata_d;

  logic full, empty, cpu_ready, accept, push, pop, ack_match;

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    ack_match = (bus.mem_ack == mem_req_q);
    // A pending read blocks everything so no write can overtake it.
    cpu_ready = !reset && !rd_pending_q && (bus.cpu_we ? !full : 1'b1);
    accept    = bus.cpu_valid && cpu_ready;
    // Writes with no byte enabled are accepted but never reach memory.
    push      = accept && bus.cpu_we && (bus.cpu_wrl || bus.cpu_wrh);
    pop       = (state_q == WR_BUSY) && ack_match;
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);
    count_d      = count_q + CW'(push) - CW'(pop);
    rd_pending_d = rd_pending_q;
    rd_addr_d    = rd_addr_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_wrl_d    = mem_wrl_q;
    mem_wrh_d    = mem_wrh_q;
    mem_req_d    = mem_req_q;
    cpu_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;

    if (accept && !bus.cpu_we) begin
      rd_pending_d = 1'b1;
      rd_addr_d    = bus.cpu_addr;
    end

    case (state_q)
      IDLE: begin
        // Nothing is outstanding here, so a late ack from an access dropped
        // by reset is absorbed by tracking mem_ack.
        mem_req_d = bus.mem_ack;
        if (!empty) begin
          mem_addr_d = fifo_q[rd_ptr_q].addr;
          mem_din_d  = fifo_q[rd_ptr_q].din;
          mem_wrl_d  = fifo_q[rd_ptr_q].wrl;
          mem_wrh_d  = fifo_q[rd_ptr_q].wrh;
          mem_req_d  = !bus.mem_ack;
          state_d    = WR_BUSY;
        end else if (rd_pending_q) begin
          state_d = RD_ISSUE;
        end
      end
      WR_BUSY: begin
        if (ack_match) state_d = IDLE;
      end
      RD_ISSUE: begin
        mem_addr_d = rd_addr_q;
        mem_din_d  = '0;
        mem_wrl_d  = 1'b0;
        mem_wrh_d  = 1'b0;
        mem_req_d  = !bus.mem_ack;
        state_d    = RD_BUSY;
      end
      RD_BUSY: begin
        if (ack_match) begin
          cpu_rdata_d  = bus.mem_dout;
          cpu_rvalid_d = 1'b1;
          rd_pending_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_wrl_q    <= 1'b0;
      mem_wrh_q    <= 1'b0;
      mem_req_q    <= bus.mem_ack;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rd_pending_q <= rd_pending_d;
      rd_addr_q    <= rd_addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_wrl_q    <= mem_wrl_d;
      mem_wrh_q    <= mem_wrh_d;
      mem_req_q    <= mem_req_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  // Entry storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {bus.cpu_addr, bus.cpu_din, bus.cpu_wrl, bus.cpu_wrh};
    end
  end

  assign bus.cpu_ready  = cpu_ready;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.mem_wrl    = mem_wrl_q;
  assign bus.mem_wrh    = mem_wrh_q;
  assign bus.mem_req    = mem_req_q;

endmodule
